seq_multdiv: RTL and testbench

Iterative unsigned multiply/divide datapath that sits directly downstream of the step counter and consumes one counter step per clock. Runs one shift-add (multiply) or restoring-subtract (divide) iteration per cycle and delivers a double-width result with a start/done handshake. It is the arithmetic stage the counter exists to sequence.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/step_counter.sv | 29 ++
 rtl/seq_multdiv.sv | 140 ++++++++++++++
 tb/tb_seq_multdiv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding, op codes and counter sizing for seq_multdiv
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Step-count width; one bit minimum so the smallest legal WIDTH still has a counter
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - modulo step counter sequencing the iteration steps
module step_counter #(
  parameter int MOD = 8,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(MOD - 1);

  assign last = (count == MAX);

  // Count enabled steps, wrapping at MOD-1; clear wins over enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/seq_multdiv.sv
// rtl/seq_multdiv.sv - iterative unsigned shift-add multiply / restoring divide
module seq_multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH + 1;

  state_t state, state_nx;

  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Shared working register: multiply uses all of it as P; divide keeps
  // R in [2W:W] and Q in [W-1:0] so both step kinds shift the same way.
  logic [PW-1:0]    work;
  logic [PW-1:0]    work_step;

  logic             accept;
  logic             dzero;
  logic             run;
  logic             last;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   hi_sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] t;

  assign run = (state == RUN);

  step_counter #(
    .MOD (WIDTH),
    .CW  (CW)
  ) u_step_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (run),
    .count  (count),
    .last   (last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; a divide by zero skips RUN and finishes in one cycle
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    dzero    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op == OP_DIV && b == '0) begin
            dzero    = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration of whichever datapath the latched op selects
  always_comb begin
    hi_sum    = work[PW-1:WIDTH] + {1'b0, (work[0] ? a_q : {WIDTH{1'b0}})};
    rs        = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    t         = {1'b0, rs} - {2'b00, b_q};
    work_step = work;
    if (op_q == OP_MUL) begin
      work_step = {1'b0, hi_sum, work[WIDTH-1:1]};
    end else if (t[WIDTH+1]) begin
      work_step = {rs, work[WIDTH-2:0], 1'b0};
    end else begin
      work_step = {t[WIDTH:0], work[WIDTH-2:0], 1'b1};
    end
  end

  // Operand latch, iteration and registered outputs; results only move on entry to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      if (accept) begin
        op_q     <= op;
        a_q      <= a;
        b_q      <= b;
        work     <= {{(WIDTH+1){1'b0}}, (op == OP_MUL) ? b : a};
        div_zero <= dzero;
        if (dzero) begin
          result_hi <= a;
          result_lo <= '1;
        end
      end else if (run) begin
        work <= work_step;
        if (last) begin
          result_hi <= work_step[2*WIDTH-1:WIDTH];
          result_lo <= work_step[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_multdiv.sv
// tb/tb_seq_multdiv.sv - scoreboard bench for seq_multdiv
module tb_seq_multdiv;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_multdiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    if (o == 1'b0) begin
      p    = x * y;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.dz = 1'b0;
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      e.hi = x % y;
      e.lo = x / y;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Compare a done-cycle result against the oldest scoreboard entry
  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: done with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({result_hi, result_lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
               name, result_hi, result_lo, div_zero, e.hi, e.lo, e.dz);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after DONE has ended
  task automatic do_op(input string name, input logic o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int exp_lat);
    int n;
    bit seen;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op = ~o; a = W'($urandom); b = W'($urandom);
    sb.push_back(model(o, x, y));
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || div_zero !== (o && y == '0)) begin
      errors++;
      $display("FAIL %s first cycle: busy=%b dz=%b, want busy=1 dz=%b", name, busy, div_zero, (o && y == '0));
    end
    n = 1; seen = 0;
    while (!seen && n <= 40) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      void'(sb.pop_front());
      return;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, exp_lat);
    end
    check_result(name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_zero, result_hi, result_lo} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
               busy, done, div_zero, result_hi, result_lo);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, result_hi, result_lo} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b hi=%h lo=%h, want all 0",
               busy, done, result_hi, result_lo);
    end
  endtask

  task automatic test_multiply();
    do_op("mul_13x11", 1'b0, 8'd13, 8'd11, 9);
  endtask

  task automatic test_back_to_back();
    do_op("mul_255x255", 1'b0, 8'd255, 8'd255, 9);
    do_op("mul_0x200", 1'b0, 8'd0, 8'd200, 9);
    do_op("mul_rand", 1'b0, 8'd171, 8'd93, 9);
  endtask

  task automatic test_divide();
    do_op("div_200_7", 1'b1, 8'd200, 8'd7, 9);
    do_op("div_7_200", 1'b1, 8'd7, 8'd200, 9);
    do_op("div_255_1", 1'b1, 8'd255, 8'd1, 9);
  endtask

  task automatic test_div_zero();
    do_op("div_5_0", 1'b1, 8'd5, 8'd0, 1);
    do_op("mul_2x3_after_dz", 1'b0, 8'd2, 8'd3, 9);
  endtask

  task automatic test_start_while_busy();
    int pulses;
    op = 1'b0; a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    sb.push_back(model(1'b0, 8'd100, 8'd3));
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op = 1'b1; a = 8'd9; b = 8'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        check_result("busy_start");
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL busy_start pulses: got %0d done pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    op = 1'b0; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero, result_hi, result_lo} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
               busy, done, div_zero, result_hi, result_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset aftermath: got %0d done pulses busy=%b, want 0 0", pulses, busy);
    end
    do_op("mul_13x11_after_reset", 1'b0, 8'd13, 8'd11, 9);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_back_to_back();
    test_divide();
    test_div_zero();
    test_start_while_busy();
    test_reset_midrun();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
